// File: rtl/queue_if.sv
// rtl/queue_if.sv - push/pop bus for the queue FIFO
//
// Purpose: groups the push/pop signals of the queue into one bundle.
// Signals:
//   insert   push request, data_i written on the rising edge
//   read     pop request
//   data_i   write data, DATA_W bits
//   valid_o  one-cycle strobe qualifying data_o
//   data_o   popped word, registered
// Modports: master = producer/consumer side, slave = queue side.

interface queue_if #(
   parameter int DATA_W = 8
);
   logic              insert;
   logic              read;
   logic [DATA_W-1:0] data_i;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;

   modport master (
      output insert,
      output read,
      output data_i,
      input  valid_o,
      input  data_o
   );

   modport slave (
      input  insert,
      input  read,
      input  data_i,
      output valid_o,
      output data_o
   );
endinterface

// File: rtl/queue.sv
// rtl/queue.sv - single-clock overwrite-on-full circular FIFO
//
// Purpose: circular FIFO of DATA_W-bit entries in an inferred synchronous
// RAM. A pop returns its word one cycle later with valid_o. When the queue
// is full a new insert overwrites the oldest entry, so the queue always
// holds the most recent DEPTH words.
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous, active-high reset
//   bus (slave)       insert, read, data_i in; valid_o, data_o out
//   full_o            count == DEPTH            (QUEUE_STATUS_EN only)
//   empty_o           count == 0                (QUEUE_STATUS_EN only)
//   level_o[ADDR_W:0] current count             (QUEUE_STATUS_EN only)
//   ovf_o             sticky insert-while-full  (QUEUE_STATUS_EN only)
// Optional feature macro: QUEUE_STATUS_EN.

module queue #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
`ifdef QUEUE_STATUS_EN
   output logic              full_o,
   output logic              empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              ovf_o,
`endif
   queue_if.slave            bus
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;

   logic full;
   logic empty;
   logic do_read;
   logic adv_rd;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // A pop on an empty queue is dropped; there is no insert-to-read bypass.
   assign do_read = bus.read && !empty;
   // The read pointer also moves on an insert into a full queue, which
   // discards the oldest entry. With a simultaneous pop it moves only once.
   assign adv_rd  = do_read || (bus.insert && full);

   // RAM write port kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (bus.insert) begin
         mem[wr_ptr] <= bus.data_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         bus.valid_o <= 1'b0;
         bus.data_o  <= '0;
      end else begin
         bus.valid_o <= do_read;
         // Nonblocking read of mem gives read-before-write when full and
         // wr_ptr == rd_ptr.
         if (do_read) begin
            bus.data_o <= mem[rd_ptr];
         end
         if (bus.insert) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (adv_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (bus.insert && !do_read && !full) begin
            count <= count + CNT_ONE;
         end else if (do_read && !bus.insert) begin
            count <= count - CNT_ONE;
         end
      end
   end

`ifdef QUEUE_STATUS_EN
   assign full_o  = full;
   assign empty_o = empty;
   assign level_o = count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_o <= 1'b0;
      end else if (bus.insert && full) begin
         ovf_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_queue.sv
// tb/tb_queue.sv - self-checking bench for the queue FIFO

module tb_queue;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   queue_if #(.DATA_W(DATA_W)) qif ();

`ifdef QUEUE_STATUS_EN
   logic            full_o;
   logic            empty_o;
   logic [ADDR_W:0] level_o;
   logic            ovf_o;
`endif

   queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst     (rst),
`ifdef QUEUE_STATUS_EN
      .full_o  (full_o),
      .empty_o (empty_o),
      .level_o (level_o),
      .ovf_o   (ovf_o),
`endif
      .bus     (qif.slave)
   );

   always #5 clk = ~clk;

   // Reference model: a plain queue holding the most recent DEPTH words.
   logic [7:0] mq [$];
   logic       exp_valid;
   logic [7:0] exp_data;
   logic       exp_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         exp_valid <= 1'b0;
         exp_data  <= 8'h00;
         exp_ovf   <= 1'b0;
      end else begin
         if (qif.insert && mq.size() == DEPTH) exp_ovf <= 1'b1;
         if (qif.read && mq.size() > 0) begin
            exp_valid <= 1'b1;
            exp_data  <= mq[0];
            mq.delete(0);
            if (qif.insert) mq.push_back(qif.data_i);
         end else begin
            exp_valid <= 1'b0;
            if (qif.insert) begin
               if (mq.size() == DEPTH) mq.delete(0);
               mq.push_back(qif.data_i);
            end
         end
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clk) begin
      n_checks++;
      if (qif.valid_o !== exp_valid || qif.data_o !== exp_data) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t valid_o=%b data_o=%02h expected valid=%b data=%02h",
                  $time, qif.valid_o, qif.data_o, exp_valid, exp_data);
      end
`ifdef QUEUE_STATUS_EN
      n_checks++;
      if (level_o !== (ADDR_W+1)'(mq.size()) || full_o !== (mq.size() == DEPTH) ||
          empty_o !== (mq.size() == 0) || ovf_o !== exp_ovf) begin
         n_fail++;
         $display("FAIL status_cmp t=%0t level=%0d full=%b empty=%b ovf=%b expected level=%0d ovf=%b",
                  $time, level_o, full_o, empty_o, ovf_o, mq.size(), exp_ovf);
      end
`endif
   end

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %03h expected %03h", name, got, exp);
      end
   endtask

   // One operation: drive at negedge, return #1 after the following posedge.
   task automatic step(input logic ins, input logic rd, input logic [7:0] d);
      @(negedge clk);
      qif.insert = ins;
      qif.read   = rd;
      qif.data_i = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00);
   endtask

   // Literal check of {valid_o, data_o}.
   task automatic chk_out(input string name, input logic v, input logic [7:0] d);
      check(name, {qif.valid_o, qif.data_o}, {v, d});
   endtask

   initial begin
      qif.insert = 1'b0;
      qif.read   = 1'b0;
      qif.data_i = 8'h00;
      #12 rst = 1'b0;
      chk_out("reset_state", 1'b0, 8'h00);

      // Data present without insert is not stored.
      step(1'b0, 1'b0, 8'hEC);
      step(1'b0, 1'b1, 8'h00);
      chk_out("no_insert_read", 1'b0, 8'h00);

      // Basic ordering and underflow.
      step(1'b1, 1'b0, 8'h01);
      step(1'b1, 1'b0, 8'h02);
      step(1'b1, 1'b0, 8'h03);
      step(1'b0, 1'b1, 8'h00);
      chk_out("rd1", 1'b1, 8'h01);
      step(1'b0, 1'b1, 8'h00);
      chk_out("rd2", 1'b1, 8'h02);
      step(1'b0, 1'b1, 8'h00);
      chk_out("rd3", 1'b1, 8'h03);
      step(1'b0, 1'b1, 8'h00);
      chk_out("underflow", 1'b0, 8'h03);
      idle();
      chk_out("idle_hold", 1'b0, 8'h03);

      // Overflow: 1030 inserts keep only i = 6..1029.
      for (int i = 0; i < 1030; i++) step(1'b1, 1'b0, i[7:0]);
      for (int i = 0; i < 1030; i++) begin
         step(1'b0, 1'b1, 8'h00);
         if (i == 0)    chk_out("ovf_first", 1'b1, 8'h06);
         if (i == 1023) chk_out("ovf_last", 1'b1, 8'h05);
         if (i == 1024) chk_out("ovf_drained", 1'b0, 8'h05);
      end

      // Simultaneous insert and read, partially filled.
      step(1'b1, 1'b0, 8'hA0);
      step(1'b1, 1'b0, 8'hA1);
      step(1'b1, 1'b1, 8'hA2);
      chk_out("sim_head", 1'b1, 8'hA0);
      step(1'b0, 1'b1, 8'h00);
      chk_out("sim_next1", 1'b1, 8'hA1);
      step(1'b0, 1'b1, 8'h00);
      chk_out("sim_next2", 1'b1, 8'hA2);

      // Simultaneous insert and read, empty: no bypass.
      step(1'b1, 1'b1, 8'h77);
      chk_out("empty_sim", 1'b0, 8'hA2);
      step(1'b0, 1'b1, 8'h00);
      chk_out("empty_sim_later", 1'b1, 8'h77);

      // Full plus simultaneous insert and read.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, i[7:0]);
      step(1'b1, 1'b1, 8'h55);
      chk_out("full_sim_head", 1'b1, 8'h00);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00);
         if (i == 0)         chk_out("full_sim_second", 1'b1, 8'h01);
         if (i == DEPTH - 1) chk_out("full_sim_final", 1'b1, 8'h55);
      end
      step(1'b0, 1'b1, 8'h00);
      chk_out("full_sim_empty", 1'b0, 8'h55);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
      step(1'b0, 1'b1, 8'h00);
      chk_out("pre_rst_read", 1'b1, 8'h30);
      qif.read = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk_out("async_rst", 1'b0, 8'h00);
      #3 rst = 1'b0;
      step(1'b0, 1'b1, 8'h00);
      chk_out("post_rst_rd1", 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      chk_out("post_rst_rd2", 1'b0, 8'h00);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
